// File: rtl/updown_counter_mc.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_mc
// Brief    : Multi-channel up/down counter advanced by prescaler tick or manual
//            step edge. Optional Gray outputs built when COUNTER_GRAY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_mc #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int DIV_BITS = 23,
  parameter int SATURATE = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      MANUAL,
  input  logic                      STEP,
  input  logic [CHANNELS-1:0]       EN,
  input  logic [CHANNELS-1:0]       DIR,
  input  logic [CHANNELS-1:0]       CLR,
  input  logic [CHANNELS-1:0]       LOAD,
  input  logic [CHANNELS*WIDTH-1:0] LOAD_VAL,
  output logic [CHANNELS*WIDTH-1:0] COUNT,
  output logic [CHANNELS*WIDTH-1:0] GRAY,
  output logic [CHANNELS-1:0]       TC,
  output logic [2:0]                ACT_N
);

  localparam logic [WIDTH-1:0]    C_MAX       = '1;
  localparam logic [WIDTH-1:0]    C_ONE       = 1;
  localparam logic [DIV_BITS-1:0] C_PRESC_ONE = 1;

  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic                step_q, step_d;
  logic                rel_q, rel_d;
  logic [2:0]          act_q, act_d;
  logic                w_tick, w_edge, w_adv;

  always_comb begin
    presc_d = presc_q + C_PRESC_ONE;
    step_d  = STEP;
    rel_d   = 1'b0;
    w_tick  = &presc_q;
    // rel_q masks the first cycle after reset so a held STEP is not an edge
    w_edge  = STEP & ~step_q & ~rel_q & ~RST;
    w_adv   = MANUAL ? w_edge : w_tick;
    act_d   = w_tick ? act_q + 3'd1 : act_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      step_q  <= 1'b0;
      rel_q   <= 1'b1;
      act_q   <= 3'd0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      rel_q   <= rel_d;
      act_q   <= act_d;
    end
  end

  assign ACT_N = ~{act_q[0], act_q[1], act_q[2]};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      if (CLR[i]) begin
        cnt_d = '0;
      end else if (LOAD[i]) begin
        cnt_d = LOAD_VAL[i*WIDTH +: WIDTH];
      end else if (w_adv && EN[i]) begin
        if (DIR[i]) begin
          if (cnt_q == C_MAX) begin
            tc_d  = 1'b1;
            cnt_d = (SATURATE != 0) ? cnt_q : '0;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end else begin
          if (cnt_q == '0) begin
            tc_d  = 1'b1;
            cnt_d = (SATURATE != 0) ? cnt_q : C_MAX;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        tc_q  <= tc_d;
      end
    end

    assign COUNT[i*WIDTH +: WIDTH] = cnt_q;
    assign TC[i]                   = tc_q;

`ifdef COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q, gray_d;

    // Encoded from the next count so GRAY lines up with COUNT
    always_comb begin
      gray_d = cnt_d ^ (cnt_d >> 1);
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        gray_q <= '0;
      end else begin
        gray_q <= gray_d;
      end
    end

    assign GRAY[i*WIDTH +: WIDTH] = gray_q;
`else
    assign GRAY[i*WIDTH +: WIDTH] = '0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_counter_mc
// Brief    : Self-checking bench for updown_counter_mc (wrap and saturate builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_counter_mc;

  localparam int W  = 4;
  localparam int CH = 2;
  localparam int DB = 3;
  localparam int PERIOD = 1 << DB;

  logic          clk = 1'b0;
  logic          rst, manual, step;
  logic [CH-1:0] en, dir, clr, load;
  logic [CH*W-1:0] load_val;
  logic [CH*W-1:0] count_w, gray_w, count_s, gray_s;
  logic [CH-1:0]   tc_w, tc_s;
  logic [2:0]      actn_w, actn_s;

  always #5 clk = ~clk;

  updown_counter_mc #(.WIDTH(W), .CHANNELS(CH), .DIV_BITS(DB), .SATURATE(0)) dut_w (
    .CLK(clk), .RST(rst), .MANUAL(manual), .STEP(step), .EN(en), .DIR(dir),
    .CLR(clr), .LOAD(load), .LOAD_VAL(load_val), .COUNT(count_w), .GRAY(gray_w),
    .TC(tc_w), .ACT_N(actn_w));

  updown_counter_mc #(.WIDTH(W), .CHANNELS(CH), .DIV_BITS(DB), .SATURATE(1)) dut_s (
    .CLK(clk), .RST(rst), .MANUAL(manual), .STEP(step), .EN(en), .DIR(dir),
    .CLR(clr), .LOAD(load), .LOAD_VAL(load_val), .COUNT(count_s), .GRAY(gray_s),
    .TC(tc_s), .ACT_N(actn_s));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle count since reset, integer counts per build/channel
  int cyc;
  bit m_stepq, m_first;
  int m_act;
  int m_cnt [2][CH];
  bit m_tc  [2][CH];

  typedef struct {
    bit       clr;
    bit       load;
    bit [3:0] lv;
    bit       dir;
    bit       en;
    int       exp_cnt;
    bit       exp_tc;
  } vec_t;

  vec_t vecs [12];

  function automatic int gray_of(int v);
`ifdef COUNTER_GRAY_EN
    return v ^ (v >> 1);
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit tick, edg, adv;
    int nxt;
    if (rst) begin
      cyc = 0; m_stepq = 0; m_first = 1; m_act = 0;
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < CH; c++) begin
          m_cnt[s][c] = 0; m_tc[s][c] = 0;
        end
      return;
    end
    tick = (cyc % PERIOD) == PERIOD - 1;
    edg  = step && !m_stepq && !m_first;
    adv  = manual ? edg : tick;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < CH; c++) begin
        m_tc[s][c] = 0;
        if (clr[c]) m_cnt[s][c] = 0;
        else if (load[c]) m_cnt[s][c] = int'(load_val[c*W +: W]);
        else if (adv && en[c]) begin
          nxt = m_cnt[s][c] + (dir[c] ? 1 : -1);
          if (nxt < 0 || nxt >= (1 << W)) begin
            m_tc[s][c] = 1;
            if (s == 0) nxt = (nxt + (1 << W)) % (1 << W);
            else nxt = m_cnt[s][c];
          end
          m_cnt[s][c] = nxt;
        end
      end
    if (tick) m_act = (m_act + 1) % 8;
    cyc++;
    m_stepq = step;
    m_first = 0;
  endtask

  task automatic check_all();
    logic [2:0] a, exp_n;
    a = m_act[2:0];
    exp_n = ~{a[0], a[1], a[2]};
    for (int c = 0; c < CH; c++) begin
      check($sformatf("cnt_w%0d", c), 32'(count_w[c*W +: W]), m_cnt[0][c]);
      check($sformatf("cnt_s%0d", c), 32'(count_s[c*W +: W]), m_cnt[1][c]);
      check($sformatf("tc_w%0d", c), 32'(tc_w[c]), 32'(m_tc[0][c]));
      check($sformatf("tc_s%0d", c), 32'(tc_s[c]), 32'(m_tc[1][c]));
      check($sformatf("gray_w%0d", c), 32'(gray_w[c*W +: W]), gray_of(m_cnt[0][c]));
      check($sformatf("gray_s%0d", c), 32'(gray_s[c*W +: W]), gray_of(m_cnt[1][c]));
    end
    check("act_n_w", 32'(actn_w), 32'(exp_n));
    check("act_n_s", 32'(actn_s), 32'(exp_n));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Advance through the next prescaler tick edge (bounded)
  task automatic run_to_tick();
    int n = 0;
    while ((cyc % PERIOD) != PERIOD - 1 && n < 2 * PERIOD) begin
      cycle();
      n++;
    end
    if (n >= 2 * PERIOD) begin
      n_checks++; n_fail++;
      $display("FAIL run_to_tick: no tick within %0d cycles, required 1", n);
    end
    cycle();
  endtask

  initial begin
    vecs[0]  = '{0, 1, 4'hF, 1, 1, 15, 0};
    vecs[1]  = '{1, 1, 4'h5, 1, 1,  0, 0};
    vecs[2]  = '{0, 1, 4'h5, 1, 1,  5, 0};
    vecs[3]  = '{0, 0, 4'h0, 1, 1,  6, 0};
    vecs[4]  = '{0, 0, 4'h0, 0, 1,  5, 0};
    vecs[5]  = '{0, 0, 4'h0, 1, 0,  5, 0};
    vecs[6]  = '{0, 1, 4'hF, 1, 0, 15, 0};
    vecs[7]  = '{0, 0, 4'h0, 1, 1,  0, 1};
    vecs[8]  = '{0, 0, 4'h0, 0, 1, 15, 1};
    vecs[9]  = '{0, 1, 4'h0, 0, 0,  0, 0};
    vecs[10] = '{0, 0, 4'h0, 0, 1, 15, 1};
    vecs[11] = '{1, 0, 4'h0, 0, 0,  0, 0};

    rst = 1; manual = 0; step = 0; en = '0; dir = '0; clr = '0; load = '0; load_val = '0;
    cycle();
    cycle();
    check("rst_count_w", 32'(count_w), 0);
    check("rst_tc_w", 32'(tc_w), 0);
    check("rst_act_n", 32'(actn_w), 32'(3'b111));
    check("rst_gray_w", 32'(gray_w), 0);

    // Prescaler: tick visible 7 cycles after release, consumed by the 8th edge
    rst = 0; en = 2'b11; dir = 2'b11;
    repeat (PERIOD - 1) cycle();
    check("presc_before_tick", 32'(count_w[0 +: W]), 0);
    cycle();
    check("presc_first_tick", 32'(count_w[0 +: W]), 1);
    check("act_first_tick", 32'(actn_w), 32'(3'b011));
    repeat (PERIOD) cycle();
    check("presc_second_tick", 32'(count_w[0 +: W]), 2);

    // Wrap up then down on ch0
    load = 2'b01; load_val = 8'h0F;
    cycle();
    load = '0;
    run_to_tick();
    check("wrap_up_cnt", 32'(count_w[0 +: W]), 0);
    check("wrap_up_tc", 32'(tc_w[0]), 1);
    check("sat_up_cnt", 32'(count_s[0 +: W]), 15);
    check("sat_up_tc", 32'(tc_s[0]), 1);
    cycle();
    check("wrap_tc_one_cycle", 32'(tc_w[0]), 0);
    dir[0] = 0;
    run_to_tick();
    check("wrap_dn_cnt", 32'(count_w[0 +: W]), 15);
    check("wrap_dn_tc", 32'(tc_w[0]), 1);

    // Saturate down at 0 on ch1
    clr = 2'b10;
    cycle();
    clr = '0; dir[1] = 0;
    for (int k = 0; k < 3; k++) begin
      run_to_tick();
      check("sat_dn_cnt", 32'(count_s[W +: W]), 0);
      check("sat_dn_tc", 32'(tc_s[1]), 1);
      cycle();
      check("sat_dn_tc_clear", 32'(tc_s[1]), 0);
    end

    // Manual step: two rising edges, ticks ignored
    manual = 1; clr = 2'b01;
    cycle();
    clr = '0; en = 2'b01; dir = 2'b11;
    step = 1; repeat (20) cycle();
    step = 0; repeat (3) cycle();
    step = 1; repeat (5) cycle();
    step = 0; cycle();
    check("manual_two_steps", 32'(count_w[0 +: W]), 2);

    // Table-driven priority / direction / wrap vectors on ch0, manual mode
    for (int v = 0; v < 12; v++) begin
      clr = {1'b0, vecs[v].clr}; load = {1'b0, vecs[v].load};
      load_val = {4'h0, vecs[v].lv}; dir = {1'b0, vecs[v].dir}; en = {1'b0, vecs[v].en};
      step = 1;
      cycle();
      check($sformatf("vec%0d_cnt", v), 32'(count_w[0 +: W]), vecs[v].exp_cnt);
      check($sformatf("vec%0d_tc", v), 32'(tc_w[0]), 32'(vecs[v].exp_tc));
      clr = '0; load = '0; step = 0;
      cycle();
    end

    // Gray sweep over 0..15 on ch0
    clr = 2'b01;
    cycle();
    clr = '0; en = 2'b01; dir = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step = 1;
      cycle();
      check("sweep_cnt", 32'(count_w[0 +: W]), k % 16);
      check("sweep_gray", 32'(gray_w[0 +: W]), gray_of(k % 16));
      if (k == 10) check("gray_of_10", 32'(gray_w[0 +: W]), gray_of(10));
      step = 0;
      cycle();
    end

    // Reset mid-operation with a wrapping advance pending
    load = 2'b01; load_val = 8'h0F;
    cycle();
    load = '0; step = 1; rst = 1;
    cycle();
    check("midrst_cnt", 32'(count_w), 0);
    check("midrst_tc", 32'(tc_w), 0);
    check("midrst_act", 32'(actn_w), 32'(3'b111));
    rst = 0;
    cycle();
    check("held_step_after_rst", 32'(count_w[0 +: W]), 0);

    // Randomised traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) manual = ~manual;
      step     = $urandom_range(0, 1);
      en       = CH'($urandom);
      dir      = CH'($urandom);
      clr      = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
      load     = {($urandom_range(0, 14) == 0), ($urandom_range(0, 14) == 0)};
      load_val = (CH*W)'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
